// File: rtl/inst_mem_loader.sv
// Boot-time instruction memory loader: frames a host byte stream as [LEN_HI][LEN_LO][N words][CSUM]
// and writes big-endian words to the instruction RAM while holding the CPU in reset.
module inst_mem_loader #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic [15:0] len_r;
    logic [15:0] len_s;
    logic [7:0]  csum_r;
    logic [1:0]  idx_r;
    logic [23:0] shift_r;
    logic        xfer_s;
    logic        word_done_s;
    logic        last_word_s;
    logic        launch_s;
    logic        enter_done_s;
    logic        enter_err_s;
    logic        ready_next_s;
    logic [31:0] addr_s;

    assign xfer_s       = byte_valid & byte_ready;
    assign len_s        = {len_r[15:8], byte_in};
    assign word_done_s  = (state_r == ST_DATA) && xfer_s && (idx_r == 2'd3);
    assign last_word_s  = word_done_s && ((word_count + 16'd1) == len_r);
    assign launch_s     = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR));
    assign enter_done_s = (state_r == ST_CSUM) && (next_state_s == ST_DONE);
    assign enter_err_s  = (state_r != ST_ERR) && (next_state_s == ST_ERR);
    // word_count doubles as the index k of the word currently being assembled
    assign addr_s       = BASE_ADDR + {14'd0, word_count, 2'b00};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    next_state_s = ST_LEN_HI;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_LEN_HI: begin
                if (xfer_s) begin
                    next_state_s = ST_LEN_LO;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_LEN_LO: begin
                if (!xfer_s) begin
                    next_state_s = state_r;
                end else if (len_s == 16'd0) begin
                    next_state_s = ST_CSUM;
                end else if ({1'b0, len_s} > DEPTH_W) begin
                    next_state_s = ST_ERR;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_DATA: begin
                if (last_word_s) begin
                    next_state_s = ST_CSUM;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_CSUM: begin
                if (!xfer_s) begin
                    next_state_s = state_r;
                end else if (byte_in == csum_r) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_ERR;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // byte_ready is registered from the next state so it tracks the state register exactly
    always_comb begin
        ready_next_s = 1'b0;
        case (next_state_s)
            ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM: ready_next_s = 1'b1;
            default:                                ready_next_s = 1'b0;
        endcase
    end

    // Control outputs: handshake, pulses and load status
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b0;
        end else begin
            byte_ready <= ready_next_s;
            mem_we     <= word_done_s;
            done       <= enter_done_s;
            if (launch_s) begin
                error    <= 1'b0;
                cpu_hold <= 1'b1;
            end else if (enter_err_s) begin
                error    <= 1'b1;
                cpu_hold <= 1'b0;
            end else if (enter_done_s) begin
                cpu_hold <= 1'b0;
            end else begin
                error    <= error;
                cpu_hold <= cpu_hold;
            end
        end
    end

    // Datapath: length capture, checksum, word assembly and RAM write registers
    always_ff @(posedge clk) begin
        if (reset) begin
            len_r      <= 16'd0;
            csum_r     <= 8'd0;
            idx_r      <= 2'd0;
            shift_r    <= 24'd0;
            mem_addr   <= 32'd0;
            mem_wd     <= 32'd0;
            word_count <= 16'd0;
        end else if (launch_s) begin
            csum_r     <= 8'd0;
            idx_r      <= 2'd0;
            word_count <= 16'd0;
        end else if (xfer_s) begin
            case (state_r)
                ST_LEN_HI: begin
                    len_r[15:8] <= byte_in;
                    csum_r      <= csum_step(csum_r, byte_in);
                end
                ST_LEN_LO: begin
                    len_r  <= len_s;
                    csum_r <= csum_step(csum_r, byte_in);
                end
                ST_DATA: begin
                    csum_r <= csum_step(csum_r, byte_in);
                    if (idx_r == 2'd3) begin
                        mem_addr   <= addr_s;
                        mem_wd     <= {shift_r, byte_in};
                        word_count <= word_count + 16'd1;
                        idx_r      <= 2'd0;
                    end else begin
                        shift_r <= {shift_r[15:0], byte_in};
                        idx_r   <= idx_r + 2'd1;
                    end
                end
                default: begin
                    csum_r <= csum_r;
                end
            endcase
        end else begin
            csum_r <= csum_r;
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: two instances (BASE_ADDR 0 and 0x100) share stimulus;
// expected RAM writes are queued per instance and popped by a write monitor.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic        br0, we0, hold0, done0, err0;
    logic [31:0] addr0, wd0;
    logic [15:0] wc0;
    logic        br1, we1, hold1, done1, err1;
    logic [31:0] addr1, wd1;
    logic [15:0] wc1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] e0, e1;

    always #5 clk = ~clk;

    inst_mem_loader #(.DEPTH(1024), .BASE_ADDR(32'h00000000)) dut0 (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(br0), .mem_we(we0), .mem_addr(addr0), .mem_wd(wd0), .cpu_hold(hold0),
        .done(done0), .error(err0), .word_count(wc0)
    );

    inst_mem_loader #(.DEPTH(1024), .BASE_ADDR(32'h00000100)) dut1 (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(br1), .mem_we(we1), .mem_addr(addr1), .mem_wd(wd1), .cpu_hold(hold1),
        .done(done1), .error(err1), .word_count(wc1)
    );

    // Write monitor / scoreboard
    always @(negedge clk) begin
        if (we0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL wr0_unexpected: got addr=%h data=%h, expected no write", addr0, wd0);
            end else begin
                e0 = q0.pop_front();
                if ({addr0, wd0} !== e0) begin
                    errors++;
                    $display("FAIL wr0: got addr=%h data=%h, expected addr=%h data=%h",
                             addr0, wd0, e0[63:32], e0[31:0]);
                end
            end
        end
        if (we1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL wr1_unexpected: got addr=%h data=%h, expected no write", addr1, wd1);
            end else begin
                e1 = q1.pop_front();
                if ({addr1, wd1} !== e1) begin
                    errors++;
                    $display("FAIL wr1: got addr=%h data=%h, expected addr=%h data=%h",
                             addr1, wd1, e1[63:32], e1[31:0]);
                end
            end
        end
        if (done0) done_cnt++;
    end

    function automatic logic [7:0] xsum(input logic [7:0] d[$]);
        logic [7:0] a;
        a = 8'h00;
        foreach (d[i]) a = a ^ d[i];
        return a;
    endfunction

    task automatic expect_word(input int k, input logic [31:0] data);
        q0.push_back({32'h00000000 + 32'(k * 4), data});
        q1.push_back({32'h00000100 + 32'(k * 4), data});
    endtask

    task automatic start_load();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit toggle);
        int n;
        if (toggle) @(negedge clk);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        n = 0;
        while (!br0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!br0) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout: got byte_ready=0 after %0d cycles, expected 1", n);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] d[$], input bit toggle);
        foreach (d[i]) send_byte(d[i], toggle);
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({br0, we0, hold0, done0, err0} !== 5'b0 || wc0 !== 16'd0) begin
            errors++;
            $display("FAIL %s_ctrl: got ready/we/hold/done/err=%b wc=%0d, expected 00000 wc=0",
                     tag, {br0, we0, hold0, done0, err0}, wc0);
        end
        checks++;
        if (addr0 !== 32'd0 || wd0 !== 32'd0 || addr1 !== 32'd0 || wd1 !== 32'd0) begin
            errors++;
            $display("FAIL %s_bus: got addr0=%h wd0=%h addr1=%h wd1=%h, expected all 0",
                     tag, addr0, wd0, addr1, wd1);
        end
    endtask

    task automatic check_end(input string tag, input int exp_done, input logic exp_err,
                             input logic [15:0] exp_wc);
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt !== exp_done) begin
            errors++;
            $display("FAIL %s_done: got %0d done cycles, expected %0d", tag, done_cnt, exp_done);
        end
        checks++;
        if (err0 !== exp_err || err1 !== exp_err) begin
            errors++;
            $display("FAIL %s_error: got %b/%b, expected %b", tag, err0, err1, exp_err);
        end
        checks++;
        if (wc0 !== exp_wc || wc1 !== exp_wc) begin
            errors++;
            $display("FAIL %s_word_count: got %0d/%0d, expected %0d", tag, wc0, wc1, exp_wc);
        end
        checks++;
        if (hold0 !== 1'b0 || br0 !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: got hold=%b ready=%b, expected 0 0", tag, hold0, br0);
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_writes: got %0d/%0d pending, expected 0", tag, q0.size(), q1.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] d[$];
        int dc;
        dc = done_cnt;
        start_load();
        checks++;
        if (hold0 !== 1'b1 || br0 !== 1'b1) begin
            errors++;
            $display("FAIL basic_start: got hold=%b ready=%b, expected 1 1", hold0, br0);
        end
        d = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h10, 8'h21, 8'h09, 8'h00, 8'h01};
        d.push_back(xsum(d));
        expect_word(0, 32'h3C080010);
        expect_word(1, 32'h21090001);
        send_bytes(d, 1'b0);
        check_end("basic", dc + 1, 1'b0, 16'd2);
        checks++;
        if (addr0 !== 32'h4 || wd0 !== 32'h21090001) begin
            errors++;
            $display("FAIL basic_hold_bus: got addr=%h data=%h, expected 00000004 21090001", addr0, wd0);
        end
    endtask

    task automatic test_zero_len();
        logic [7:0] d[$];
        int dc;
        dc = done_cnt;
        start_load();
        d = '{8'h00, 8'h00, 8'h00};
        send_bytes(d, 1'b0);
        check_end("zero", dc + 1, 1'b0, 16'd0);
    endtask

    task automatic test_oversize();
        logic [7:0] d[$];
        int dc;
        dc = done_cnt;
        start_load();
        d = '{8'h04, 8'h01};
        send_bytes(d, 1'b0);
        check_end("oversize", dc, 1'b1, 16'd0);
    endtask

    task automatic test_bad_csum();
        logic [7:0] d[$];
        int dc;
        dc = done_cnt;
        start_load();
        checks++;
        if (err0 !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_error: got %b, expected 0", err0);
        end
        // correct checksum for this frame is 0x0F, so 0x18 must be rejected
        d = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h10, 8'h21, 8'h09, 8'h00, 8'h01, 8'h18};
        expect_word(0, 32'h3C080010);
        expect_word(1, 32'h21090001);
        send_bytes(d, 1'b0);
        check_end("badcsum", dc, 1'b1, 16'd2);
        start_load();
        checks++;
        if (err0 !== 1'b0 || wc0 !== 16'd0) begin
            errors++;
            $display("FAIL restart_clear: got err=%b wc=%0d, expected 0 0", err0, wc0);
        end
        d = '{8'h00, 8'h00, 8'h00};
        send_bytes(d, 1'b0);
        check_end("recover", dc + 1, 1'b0, 16'd0);
    endtask

    task automatic test_toggle_and_reset();
        logic [7:0] d[$];
        int dc;
        dc = done_cnt;
        start_load();
        d = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h10, 8'h21, 8'h09, 8'h00, 8'h01};
        d.push_back(xsum(d));
        expect_word(0, 32'h3C080010);
        expect_word(1, 32'h21090001);
        send_bytes(d, 1'b1);
        check_end("toggle", dc + 1, 1'b0, 16'd2);

        start_load();
        d = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h10};
        expect_word(0, 32'h3C080010);
        send_bytes(d, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("midreset");
        reset      = 1'b0;
        byte_in    = 8'h55;
        byte_valid = 1'b1;
        repeat (6) @(negedge clk);
        byte_valid = 1'b0;
        checks++;
        if (br0 !== 1'b0 || wc0 !== 16'd0 || q0.size() != 0) begin
            errors++;
            $display("FAIL after_reset: got ready=%b wc=%0d pending=%0d, expected 0 0 0",
                     br0, wc0, q0.size());
        end
    endtask

    task automatic test_start_ignored();
        logic [7:0] d[$];
        logic [7:0] head[$];
        logic [7:0] tail[$];
        int dc;
        dc = done_cnt;
        start_load();
        d = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h10, 8'h21, 8'h09, 8'h00, 8'h01};
        d.push_back(xsum(d));
        expect_word(0, 32'h3C080010);
        expect_word(1, 32'h21090001);
        head = d[0:2];
        tail = d[3:$];
        send_bytes(head, 1'b0);
        start_load();
        checks++;
        if (br0 !== 1'b1 || hold0 !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored: got ready=%b hold=%b, expected 1 1", br0, hold0);
        end
        send_bytes(tail, 1'b0);
        check_end("startign", dc + 1, 1'b0, 16'd2);
        checks++;
        if (addr1 !== 32'h104) begin
            errors++;
            $display("FAIL base_addr_last: got %h, expected 00000104", addr1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_oversize();
        test_bad_csum();
        test_toggle_and_reset();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got no completion by 200000 time units, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
